// File: rtl/ysyx_22050019_axi_pkg.sv
// ysyx_22050019_axi_pkg: AXI read response codes, read FSM state encoding and doubleword alignment helper shared by the read slave and fetch initiator
package ysyx_22050019_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DELAY, ST_RESP} rd_state_e;
  function automatic logic [63:0] dw_align(input logic [63:0] a);
    return a & ~64'h7;
  endfunction
endpackage

// File: rtl/ysyx_22050019_delay_cnt.sv
// ysyx_22050019_delay_cnt: 4-bit loadable down counter with zero flag (clk, rst_n active-high sync, load/load_val, dec, zero)
module ysyx_22050019_delay_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst_n ? 4'd0 : load ? load_val : (dec && !zero) ? cnt - 4'd1 : cnt;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/ysyx_22050019_axi_rd_slave.sv
// ysyx_22050019_axi_rd_slave: single-outstanding AXI read slave over a 1-cycle SRAM (AR in, R out, mem_ren/mem_raddr/mem_rdata to SRAM, rst_n active-high sync); YSYX_22050019_AXI_RD_ERR_EN adds SLVERR for addresses outside [MEM_BASE, MEM_BASE+MEM_SIZE)
module ysyx_22050019_axi_rd_slave
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned LATENCY  = 0,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata
);
  localparam logic [3:0] LOAD_VAL = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  rd_state_e state, state_nxt;
  logic ar_hs, addr_err, in_win, cnt_load, cnt_dec, cnt_zero;
  assign in_win = (s_axi_araddr - MEM_BASE) < MEM_SIZE;
`ifdef YSYX_22050019_AXI_RD_ERR_EN
  assign addr_err = !in_win;
`else
  logic unused_in_win;
  assign unused_in_win = in_win;
  assign addr_err = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst_n ? ST_IDLE : state_nxt;
  always_comb
    state_nxt = (state == ST_IDLE)  ? (ar_hs ? ST_FETCH : ST_IDLE) :
                (state == ST_FETCH) ? ((LATENCY == 0) ? ST_RESP : ST_DELAY) :
                (state == ST_DELAY) ? (cnt_zero ? ST_RESP : ST_DELAY) :
                (s_axi_rready ? ST_IDLE : ST_RESP);
  always_comb begin
    s_axi_arready = !rst_n && state == ST_IDLE;
    s_axi_rvalid  = !rst_n && state == ST_RESP;
    ar_hs         = s_axi_arvalid && s_axi_arready;
    mem_ren       = ar_hs && !addr_err;
    mem_raddr     = dw_align(s_axi_araddr);
    cnt_load      = state == ST_FETCH;
    cnt_dec       = state == ST_DELAY;
  end
  // rresp is latched at AR acceptance and doubles as the error flag for the FETCH capture
  always_ff @(posedge clk)
    if (rst_n) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      if (ar_hs) s_axi_rresp <= addr_err ? RESP_SLVERR : RESP_OKAY;
      if (state == ST_FETCH) s_axi_rdata <= (s_axi_rresp == RESP_SLVERR) ? '0 : mem_rdata;
    end
  ysyx_22050019_delay_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );
endmodule

// File: tb/tb_ysyx_22050019_axi_rd_slave.sv
// tb_ysyx_22050019_axi_rd_slave: scoreboard bench for the AXI read slave at LATENCY 0 and 3
module tb_ysyx_22050019_axi_rd_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;
`ifdef YSYX_22050019_AXI_RD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [63:0] araddr [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [63:0] rdata [2];
  logic [1:0]  rresp [2];
  logic        rvalid [2];
  logic        rready [2];
  logic        mem_ren [2];
  logic [63:0] mem_raddr [2];
  logic [63:0] mem_rdata [2];
  logic [66:0] sb [$];
  logic [66:0] sb_e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_22050019_axi_rd_slave #(.LATENCY(g * 3)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axi_araddr  (araddr[g]),
      .s_axi_arvalid (arvalid[g]),
      .s_axi_arready (arready[g]),
      .s_axi_rdata   (rdata[g]),
      .s_axi_rresp   (rresp[g]),
      .s_axi_rvalid  (rvalid[g]),
      .s_axi_rready  (rready[g]),
      .mem_ren       (mem_ren[g]),
      .mem_raddr     (mem_raddr[g]),
      .mem_rdata     (mem_rdata[g])
    );
  end
  function automatic logic [63:0] model(input logic [63:0] a);
    return (a == 64'h8000_0000) ? 64'h1234_5678_9ABC_DEF0 : {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction
  function automatic logic is_err(input logic [63:0] a);
    return ERR_EN && (a < BASE || a >= BASE + SIZE);
  endfunction
  function automatic logic [66:0] expect_of(input int d, input logic [63:0] a);
    return {1'(d), is_err(a) ? 2'b10 : 2'b00, is_err(a) ? 64'h0 : model(a & ~64'h7)};
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      mem_rdata[i] <= mem_ren[i] ? model(mem_raddr[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (!rst_n && rvalid[i] && rready[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL r_beat_unexpected dut%0d got rresp=%b rdata=%h, expected no beat", i, rresp[i], rdata[i]);
        end else begin
          sb_e = sb.pop_front();
          if ({1'(i), rresp[i], rdata[i]} !== sb_e) begin
            errors++;
            $display("FAIL r_beat dut%0d got rresp=%b rdata=%h, expected dut%0d rresp=%b rdata=%h",
                     i, rresp[i], rdata[i], sb_e[66], sb_e[65:64], sb_e[63:0]);
          end
        end
      end
  task automatic test_reset;
    rst_n = 1'b1;
    arvalid[0] = 1'b1;
    araddr[0] = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (arready[0] !== 1'b0) begin errors++; $display("FAIL rst_arready got %b expected 0", arready[0]); end
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b expected 0", rvalid[0]); end
    checks++; if (rresp[0] !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b expected 00", rresp[0]); end
    checks++; if (rdata[0] !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h expected 0", rdata[0]); end
    checks++; if (mem_ren[0] !== 1'b0) begin errors++; $display("FAIL rst_mem_ren got %b expected 0", mem_ren[0]); end
    @(posedge clk); #1;
    arvalid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (arready[0] !== 1'b1) begin errors++; $display("FAIL rst_release_arready got %b expected 1", arready[0]); end
  endtask
  task automatic do_read(input int d, input logic [63:0] a, input int hold, input string nm);
    int n;
    int lat;
    bit busy_bad;
    bit stable;
    logic [63:0] d0;
    logic [1:0] r0;
    lat = d ? 3 : 0;
    sb.push_back(expect_of(d, a));
    @(posedge clk); #1;
    araddr[d] = a;
    arvalid[d] = 1'b1;
    rready[d] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (arready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (arready[d] !== 1'b1) begin errors++; $display("FAIL %s ar_accept got arready=%b expected 1", nm, arready[d]); end
    checks++; if (mem_ren[d] !== !is_err(a)) begin errors++; $display("FAIL %s mem_ren got %b expected %b", nm, mem_ren[d], !is_err(a)); end
    checks++; if (mem_raddr[d] !== (a & ~64'h7)) begin errors++; $display("FAIL %s mem_raddr got %h expected %h", nm, mem_raddr[d], a & ~64'h7); end
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    n = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (arready[d] !== 1'b0) busy_bad = 1'b1;
    end while (rvalid[d] !== 1'b1 && n < 40);
    checks++; if (n != 2 + lat) begin errors++; $display("FAIL %s rvalid_cycle got T+%0d expected T+%0d", nm, n, 2 + lat); end
    checks++; if (busy_bad) begin errors++; $display("FAIL %s arready_busy got 1 expected 0 while busy", nm); end
    if (hold > 0) begin
      d0 = rdata[d];
      r0 = rresp[d];
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        if (rvalid[d] !== 1'b1 || rdata[d] !== d0 || rresp[d] !== r0) stable = 1'b0;
        if (k < hold - 1) @(negedge clk);
      end
      checks++; if (!stable) begin errors++; $display("FAIL %s r_hold_stable got unstable expected stable for %0d cycles", nm, hold); end
      @(posedge clk); #1;
      rready[d] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready[d] = 1'b0;
    @(negedge clk);
    checks++; if (arready[d] !== 1'b1 || rvalid[d] !== 1'b0) begin errors++; $display("FAIL %s post_idle got arready=%b rvalid=%b expected 1/0", nm, arready[d], rvalid[d]); end
  endtask
  task automatic test_basic;
    do_read(0, 64'h8000_0004, 0, "lat0_basic");
    do_read(1, 64'h8000_0004, 0, "lat3_basic");
  endtask
  task automatic test_hold;
    do_read(0, BASE + 64'h40, 4, "lat0_hold");
    do_read(1, BASE + 64'h4C, 4, "lat3_hold");
  endtask
  task automatic test_reset_mid;
    bit seen;
    @(posedge clk); #1;
    araddr[1] = BASE + 64'h8;
    arvalid[1] = 1'b1;
    rready[1] = 1'b1;
    @(negedge clk);
    checks++; if (arready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_ar_accept got %b expected 1", arready[1]); end
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (arready[1] !== 1'b0 || rvalid[1] !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset got arready=%b rvalid=%b expected 0/0", arready[1], rvalid[1]); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (arready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_arready got %b expected 1", arready[1]); end
    seen = 1'b0;
    repeat (8) begin
      if (rvalid[1] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_beat got rvalid=1 expected 0"); end
    rready[1] = 1'b0;
    do_read(1, BASE + 64'h10, 0, "rstmid_next");
  endtask
  task automatic test_addr_range;
    do_read(0, 64'h0000_1000, 0, "lat0_low");
    do_read(1, 64'h0000_1000, 2, "lat3_low");
    do_read(0, BASE - 64'h8, 0, "below_base");
    do_read(0, BASE + SIZE - 64'h4, 0, "top_in");
    do_read(1, BASE + SIZE, 0, "top_out");
  endtask
  task automatic test_back_to_back(input int d);
    int last_r;
    int nar;
    int n;
    bit bad;
    bit upd;
    logic [63:0] a;
    a = BASE + 64'h100;
    @(posedge clk); #1;
    araddr[d] = a;
    arvalid[d] = 1'b1;
    rready[d] = 1'b1;
    last_r = -1;
    nar = 0;
    bad = 1'b0;
    upd = 1'b0;
    for (int cyc = 0; cyc < 60 && nar < 4; cyc++) begin
      @(negedge clk);
      if (rvalid[d] && rready[d]) last_r = cyc;
      if (arvalid[d] && arready[d]) begin
        if (nar > 0 && cyc != last_r + 1) bad = 1'b1;
        sb.push_back(expect_of(d, a));
        nar++;
        upd = 1'b1;
      end
      @(posedge clk); #1;
      if (upd) begin
        a += 64'h1C;
        araddr[d] = a;
        upd = 1'b0;
      end
    end
    arvalid[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    rready[d] = 1'b0;
    checks++; if (nar != 4) begin errors++; $display("FAIL b2b_dut%0d ar_count got %0d expected 4", d, nar); end
    checks++; if (bad) begin errors++; $display("FAIL b2b_dut%0d ar_spacing got gap!=1 expected accept one cycle after R", d); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_dut%0d drain got %0d pending expected 0", d, sb.size()); end
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0;
      arvalid[i] = 1'b0;
      rready[i] = 1'b0;
    end
    test_reset;
    test_basic;
    test_hold;
    test_reset_mid;
    test_addr_range;
    test_back_to_back(0);
    test_back_to_back(1);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_final got %0d pending expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
